// File: rtl/rf_param.sv
// Parametrised register file: two combinational read ports, one synchronous write port,
// optional hard-wired zero register, write bypass, pending-write scoreboard and bulk clear.
module rf_param #(
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr3,
    input  logic [WIDTH-1:0]  data3,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    output logic [WIDTH-1:0]  data1,
    output logic [WIDTH-1:0]  data2,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              pend1,
    output logic              pend2,
    input  logic              clear,
    output logic              clear_busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;

    logic idle;
    logic start_clear;
    logic wr_en;
    logic rsv_en;
    logic last_clear;

    // A clear request in IDLE takes priority: write and reserve in that cycle are dropped.
    assign idle        = (state_q == IDLE);
    assign start_clear = idle && clear;
    assign wr_en       = idle && write && !clear
                         && !((ZERO_REG != 0) && (addr3 == '0));
    assign rsv_en      = idle && rsv && !clear
                         && !((ZERO_REG != 0) && (rsv_addr == '0));
    assign last_clear  = (cnt_q == ADDR_W'(DEPTH - 1));
    assign clear_busy  = (state_q == CLEAR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clear) state_d = CLEAR;
            CLEAR:   if (last_clear) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_clear) begin
                cnt_q <= '0;
            end else if (state_q == CLEAR) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (state_q == CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (wr_en) begin
            regs_q[addr3] <= data3;
        end
    end

    // Reserve is applied after the write so it wins when both target the same register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else if (start_clear) begin
            pend_q <= '0;
        end else begin
            if (wr_en) pend_q[addr3] <= 1'b0;
            if (rsv_en) pend_q[rsv_addr] <= 1'b1;
        end
    end

    // Zero register never gets written, so its stored value and bypass gating keep reads at 0.
    assign data1 = ((BYPASS != 0) && wr_en && (addr1 == addr3)) ? data3 : regs_q[addr1];
    assign data2 = ((BYPASS != 0) && wr_en && (addr2 == addr3)) ? data3 : regs_q[addr2];
    assign pend1 = pend_q[addr1];
    assign pend2 = pend_q[addr2];

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: default, no-bypass and zero-register/wide instances
// driven from one linear sequence with immediate-assertion checks.
module tb_rf_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        write, rsv, clear;
    logic [1:0]  addr1, addr2, addr3, rsv_addr;
    logic [15:0] data3;
    logic [15:0] a_data1, a_data2, b_data1, b_data2;
    logic        a_pend1, a_pend2, a_busy, b_pend1, b_pend2, b_busy;

    logic        c_write, c_rsv, c_clear;
    logic [2:0]  c_addr1, c_addr2, c_addr3, c_rsv_addr;
    logic [31:0] c_data3, c_data1, c_data2;
    logic        c_pend1, c_pend2, c_busy;

    int errors = 0;
    int checks = 0;
    int n;

    rf_param u_a (
        .clk(clk), .reset_n(reset_n), .write(write), .addr3(addr3), .data3(data3),
        .addr1(addr1), .addr2(addr2), .data1(a_data1), .data2(a_data2),
        .rsv(rsv), .rsv_addr(rsv_addr), .pend1(a_pend1), .pend2(a_pend2),
        .clear(clear), .clear_busy(a_busy)
    );

    rf_param #(.BYPASS(0)) u_b (
        .clk(clk), .reset_n(reset_n), .write(write), .addr3(addr3), .data3(data3),
        .addr1(addr1), .addr2(addr2), .data1(b_data1), .data2(b_data2),
        .rsv(rsv), .rsv_addr(rsv_addr), .pend1(b_pend1), .pend2(b_pend2),
        .clear(clear), .clear_busy(b_busy)
    );

    rf_param #(.WIDTH(32), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_c (
        .clk(clk), .reset_n(reset_n), .write(c_write), .addr3(c_addr3), .data3(c_data3),
        .addr1(c_addr1), .addr2(c_addr2), .data1(c_data1), .data2(c_data2),
        .rsv(c_rsv), .rsv_addr(c_rsv_addr), .pend1(c_pend1), .pend2(c_pend2),
        .clear(c_clear), .clear_busy(c_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        write = 1'b0; rsv = 1'b0; clear = 1'b0;
        addr1 = '0; addr2 = '0; addr3 = '0; rsv_addr = '0; data3 = '0;
        c_write = 1'b0; c_rsv = 1'b0; c_clear = 1'b0;
        c_addr1 = '0; c_addr2 = '0; c_addr3 = '0; c_rsv_addr = '0; c_data3 = '0;

        // Reset state
        #1;
        chk("rst_a_data1", a_data1, 0);
        chk("rst_a_data2", a_data2, 0);
        chk("rst_a_pend", {a_pend1, a_pend2}, 0);
        chk("rst_a_busy", a_busy, 0);
        chk("rst_c_data", c_data1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Bypass vs no bypass on write of 0xBEEF to addr 2
        @(negedge clk);
        write = 1'b1; addr3 = 2'd2; data3 = 16'hBEEF; addr1 = 2'd2; addr2 = 2'd2;
        #1;
        chk("byp_a_data1", a_data1, 32'hBEEF);
        chk("byp_b_data1_same_cycle", b_data1, 0);
        @(negedge clk);
        write = 1'b0;
        #1;
        chk("byp_b_data1_after_edge", b_data1, 32'hBEEF);
        chk("byp_a_data2_stored", a_data2, 32'hBEEF);

        // Reserve then reserve+write to addr 3, then a plain write clears pending
        @(negedge clk);
        rsv = 1'b1; rsv_addr = 2'd3; addr1 = 2'd3;
        #1;
        chk("rsv_pend_not_yet", a_pend1, 0);
        @(negedge clk);
        write = 1'b1; addr3 = 2'd3; data3 = 16'h1234;
        #1;
        chk("rsv_pend_set", a_pend1, 1);
        chk("rsv_pend2_other", a_pend2, 0);
        @(negedge clk);
        rsv = 1'b0; write = 1'b0;
        #1;
        chk("rsv_wins_pend", a_pend1, 1);
        chk("rsv_wr_data", b_data1, 32'h1234);
        @(negedge clk);
        write = 1'b1; data3 = 16'h5678;
        #1;
        chk("wr2_pend_before_edge", a_pend1, 1);
        chk("wr2_bypass", a_data1, 32'h5678);
        @(negedge clk);
        write = 1'b0;
        #1;
        chk("wr2_pend_cleared", a_pend1, 0);
        chk("wr2_stored", b_data1, 32'h5678);

        // Fill registers 0x1111..0x4444
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            write = 1'b1; addr3 = 2'(i); data3 = 16'h1111 * 16'(i + 1);
        end
        @(negedge clk);
        write = 1'b0; rsv = 1'b1; rsv_addr = 2'd1; addr1 = 2'd0; addr2 = 2'd3;
        #1;
        chk("fill_reg0", b_data1, 32'h1111);
        chk("fill_reg3", b_data2, 32'h4444);

        // Clear wins over a simultaneous write (no bypass of the dropped write)
        @(negedge clk);
        rsv = 1'b0; clear = 1'b1; write = 1'b1; addr3 = 2'd2; data3 = 16'hAAAA;
        addr1 = 2'd1; addr2 = 2'd2;
        #1;
        chk("clr_pend_before", a_pend1, 1);
        chk("clr_wins_no_bypass", a_data2, 32'h3333);

        // Count busy cycles; writes and reserves during CLEAR are dropped
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear = 1'b0;
            #1;
            if (!a_busy) break;
            n++;
            if (i == 0) begin
                chk("clr_pend_wiped", a_pend1, 0);
                chk("clr_no_bypass", a_data2, 32'h3333);
            end
            write = 1'b1; addr3 = 2'd3; data3 = 16'hFFFF;
            rsv = 1'b1; rsv_addr = 2'd3;
        end
        chk("clr_busy_cycles", n, 4);
        rsv = 1'b0; write = 1'b1; addr3 = 2'd0; data3 = 16'h5555;
        @(negedge clk);
        write = 1'b0; addr1 = 2'd0; addr2 = 2'd3;
        #1;
        chk("clr_first_idle_write", b_data1, 32'h5555);
        chk("clr_reg3_zero", b_data2, 0);
        chk("clr_reg3_pend_dropped", a_pend2, 0);
        addr1 = 2'd1; addr2 = 2'd2;
        #1;
        chk("clr_reg1_zero", a_data1, 0);
        chk("clr_reg2_zero", a_data2, 0);

        // Zero register on the wide instance
        @(negedge clk);
        c_write = 1'b1; c_addr3 = 3'd0; c_data3 = 32'hDEADBEEF;
        c_rsv = 1'b1; c_rsv_addr = 3'd0; c_addr1 = 3'd0; c_addr2 = 3'd7;
        #1;
        chk("zr_bypass_zero", c_data1, 0);
        @(negedge clk);
        c_rsv = 1'b0; c_addr3 = 3'd7; c_data3 = 32'hCAFEF00D;
        #1;
        chk("zr_pend0", c_pend1, 0);
        chk("zr_reg0_stored", c_data1, 0);
        chk("zr_bypass7", c_data2, 32'hCAFEF00D);
        @(negedge clk);
        c_write = 1'b0;
        #1;
        chk("zr_reg7_stored", c_data2, 32'hCAFEF00D);

        // Reset asserted during cycle 2 of a bulk clear
        @(negedge clk);
        write = 1'b1; addr3 = 2'd2; data3 = 16'h7777;
        @(negedge clk);
        write = 1'b0; clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        #1;
        chk("mid_busy_before", a_busy, 1);
        chk("mid_reg2_before", a_data2, 32'h7777);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_busy_drop", a_busy, 0);
        chk("mid_reg2_zero", a_data2, 0);
        chk("mid_c_reg7_zero", c_data2, 0);
        chk("mid_pend", {a_pend1, a_pend2, c_pend2}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            clear = 1'b0;
            #1;
            if (!a_busy) break;
            n++;
        end
        chk("mid_reclear_cycles", n, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_param.md
# rf_param

Parametrised synchronous-write, combinational-read register file with two read ports and one write port. It is the generalised successor of the 4×16 datapath register file. It adds:
- configurable width and depth
- an optional hard-wired zero register
- write-to-read bypass
- a per-register pending-write scoreboard
- a multi-cycle bulk-clear engine

It sits between decode/issue, which reads operands and reserves destinations, and writeback, which writes results.

## Interface
- WIDTH, 16, data width of each register
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 0, when 1 register 0 is hard-wired to zero
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- write  in  1  write enable for addr3/data3
- addr3  in  ADDR_W  write address
- data3  in  WIDTH  write data
- addr1  in  ADDR_W  read port 1 address
- addr2  in  ADDR_W  read port 2 address
- data1  out  WIDTH  read port 1 data (combinational)
- data2  out  WIDTH  read port 2 data (combinational)
- rsv  in  1  reserve: mark rsv_addr as pending a write
- rsv_addr  in  ADDR_W  register to reserve
- pend1  out  1  pending bit of addr1 (combinational)
- pend2  out  1  pending bit of addr2 (combinational)
- clear  in  1  start bulk clear (pulse)
- clear_busy  out  1  bulk clear in progress

## Operation
- Storage: DEPTH × WIDTH registers plus a DEPTH-bit pending vector.
- Asynchronous reset (reset_n low), held until release:
  - all registers and pending bits are 0
  - FSM is IDLE, clear counter is 0, clear_busy is 0
  - data1, data2, pend1 and pend2 all read 0
- Write: on a rising clk with write=1 in IDLE, reg[addr3] <= data3 and pending[addr3] <= 0.
- Read: dataN = reg[addrN].
- Bypass: when BYPASS=1, write=1, IDLE and addrN==addr3, then dataN = data3.
- Reserve: on a rising clk with rsv=1 in IDLE, pending[rsv_addr] <= 1.
- Reserve and write to the same address in one cycle: reserve wins, so the pending bit ends at 1 and the data is written.
- ZERO_REG=1:
  - writes to address 0 are ignored
  - reads of address 0 return 0, including under bypass
  - reserving address 0 is ignored, so pend for address 0 is always 0
- Bulk clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clear=1. On that edge the counter is set to 0 and all pending bits are cleared.
  - In CLEAR, each clk sets reg[cnt] <= 0 and cnt <= cnt+1.
  - When cnt==DEPTH-1, that register is zeroed and the FSM returns to IDLE. Counter width is ADDR_W, so the wrap to 0 is natural.
  - clear_busy = (state==CLEAR).
- While clear_busy=1:
  - write, rsv and clear are ignored (dropped, not queued)
  - bypass is disabled
  - reads return the current stored contents, which mix zeroed and not-yet-cleared registers
- clear=1 together with write/rsv in IDLE: clear wins and write/rsv are dropped.
- Reset asserted mid-clear: immediate return to IDLE with everything zero.

## Timing
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle (visible after the edge) with BYPASS=0.
- Reserve-to-pend latency: 1 cycle. Write-to-pend-clear latency: 1 cycle.
- Bulk clear takes exactly DEPTH cycles:
  - clear_busy rises after the edge that samples clear
  - clear_busy falls after the DEPTH-th CLEAR edge
  - first write is accepted on the following edge
- All state changes happen on the rising clk edge except reset, which is asynchronous assert; release is sampled on the next edge.
- Read paths and pend outputs are purely combinational from the addresses and state.

## Test plan
- Reset, defaults (WIDTH=16, ADDR_W=2): pulse reset_n low mid-cycle -> all regs, data1/2, pend1/2 and clear_busy read 0 immediately.
- Write 0xBEEF to addr 2 with addr1=2, BYPASS=1 -> data1=0xBEEF in the same cycle. With BYPASS=0 -> data1=0 that cycle and 0xBEEF after the edge.
- rsv to addr 3, then next cycle rsv+write to addr 3 with 0x1234 -> pend stays 1 and reg3=0x1234. A further write of 0x5678 -> pend1 (addr1=3) becomes 0.
- Fill regs with 0x1111..0x4444, pulse clear:
  - clear_busy is high for exactly 4 cycles
  - a write of 0xFFFF to addr 3 during CLEAR is dropped
  - all regs read 0 afterwards
  - a write in the first IDLE cycle is accepted
- ZERO_REG=1, ADDR_W=3, WIDTH=32: write 0xDEADBEEF to addr 0 with bypass and rsv to addr 0 -> data1=0 and pend1=0. A write to addr 7 reads back correctly.
- Assert reset_n low during cycle 2 of a bulk clear -> clear_busy drops immediately, and after release a new clear runs its full DEPTH cycles.
